// File: rtl/mbist_sched.sv
// mbist_sched: runs the per-bank MBIST engines one bank at a time and collects fail/timeout maps.
// Optional build macro MBIST_SCHED_STOP_ON_FAIL_EN ends the sequence at the first failing bank.
module mbist_sched #(
    parameter int unsigned NUM_BANKS      = 4,
    parameter int unsigned BANK_W         = 2,
    parameter int unsigned TO_W           = 24,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                 bist_clk,
    input  logic                 bist_reset_n,
    input  logic                 sched_start,
    input  logic                 sched_abort,
    input  logic [NUM_BANKS-1:0] bank_mask,
    input  logic [NUM_BANKS-1:0] bist_done,
    input  logic [NUM_BANKS-1:0] bist_fail,
    output logic [NUM_BANKS-1:0] bist_test_enable,
    output logic                 func_hold,
    output logic                 sched_busy,
    output logic                 sched_done,
    output logic                 sched_pass,
    output logic [BANK_W-1:0]    cur_bank,
    output logic [NUM_BANKS-1:0] fail_map,
    output logic [NUM_BANKS-1:0] timeout_map
);

    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_LAUNCH,
        S_WAIT,
        S_NEXT,
        S_DONE
    } state_e;

    state_e               state_q, state_d;
    logic [BANK_W-1:0]    cur_q, cur_d;
    logic [NUM_BANKS-1:0] mask_q, mask_d;
    logic [TO_W-1:0]      timer_q, timer_d;
    logic [NUM_BANKS-1:0] fail_q, fail_d;
    logic [NUM_BANKS-1:0] to_q, to_d;
    logic [NUM_BANKS-1:0] en_q, en_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;

    // State and registered outputs
    always_ff @(posedge bist_clk or negedge bist_reset_n) begin
        if (!bist_reset_n) begin
            state_q <= S_IDLE;
            cur_q   <= '0;
            mask_q  <= '0;
            timer_q <= '0;
            fail_q  <= '0;
            to_q    <= '0;
            en_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            mask_q  <= mask_d;
            timer_q <= timer_d;
            fail_q  <= fail_d;
            to_q    <= to_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    // Next-state logic; abort freezes maps and bank index while returning to idle
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        mask_d  = mask_q;
        timer_d = timer_q;
        fail_d  = fail_q;
        to_d    = to_q;

        if (sched_abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (sched_start) begin
                        mask_d  = bank_mask;
                        fail_d  = '0;
                        to_d    = '0;
                        cur_d   = '0;
                        state_d = (bank_mask == '0) ? S_DONE : S_SELECT;
                    end
                end
                S_SELECT: begin
                    state_d = mask_q[cur_q] ? S_LAUNCH : S_NEXT;
                end
                S_LAUNCH: begin
                    timer_d = '0;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    timer_d = timer_q + TO_W'(1);
                    if (bist_fail[cur_q]) begin
                        fail_d[cur_q] = 1'b1;
                    end
                    if (bist_done[cur_q]) begin
                        state_d = S_NEXT;
                    end else if (timer_q == TO_LAST) begin
                        to_d[cur_q]   = 1'b1;
                        fail_d[cur_q] = 1'b1;
                        state_d       = S_NEXT;
                    end
                end
                S_NEXT: begin
`ifdef MBIST_SCHED_STOP_ON_FAIL_EN
                    if (fail_q[cur_q] || (cur_q == LAST_BANK)) begin
                        state_d = S_DONE;
                    end else begin
                        cur_d   = cur_q + BANK_W'(1);
                        state_d = S_SELECT;
                    end
`else
                    if (cur_q == LAST_BANK) begin
                        state_d = S_DONE;
                    end else begin
                        cur_d   = cur_q + BANK_W'(1);
                        state_d = S_SELECT;
                    end
`endif
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they line up with the registered state
    always_comb begin
        en_d   = (state_d == S_LAUNCH) ? (NUM_BANKS'(1) << cur_d) : '0;
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        pass_d = (state_d == S_DONE) && (fail_d == '0);
    end

    assign bist_test_enable = en_q;
    assign func_hold        = busy_q;
    assign sched_busy       = busy_q;
    assign sched_done       = done_q;
    assign sched_pass       = pass_q;
    assign cur_bank         = cur_q;
    assign fail_map         = fail_q;
    assign timeout_map      = to_q;

endmodule

// File: tb/tb_mbist_sched.sv
// tb_mbist_sched: directed and randomized sequences against a cycle-count reference model of the scheduler.
// Engines are modelled as fixed done latencies plus optional fail pulses per bank.
module tb_mbist_sched;

    localparam int T = 16;

    logic       bist_clk = 1'b0;
    logic       bist_reset_n;
    logic       sched_start;
    logic       sched_abort;
    logic [3:0] bank_mask;
    logic [3:0] bist_done;
    logic [3:0] bist_fail;
    logic [3:0] bist_test_enable;
    logic       func_hold;
    logic       sched_busy;
    logic       sched_done;
    logic       sched_pass;
    logic [1:0] cur_bank;
    logic [3:0] fail_map;
    logic [3:0] timeout_map;

    mbist_sched #(
        .NUM_BANKS     (4),
        .BANK_W        (2),
        .TO_W          (24),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .bist_clk        (bist_clk),
        .bist_reset_n    (bist_reset_n),
        .sched_start     (sched_start),
        .sched_abort     (sched_abort),
        .bank_mask       (bank_mask),
        .bist_done       (bist_done),
        .bist_fail       (bist_fail),
        .bist_test_enable(bist_test_enable),
        .func_hold       (func_hold),
        .sched_busy      (sched_busy),
        .sched_done      (sched_done),
        .sched_pass      (sched_pass),
        .cur_bank        (cur_bank),
        .fail_map        (fail_map),
        .timeout_map     (timeout_map)
    );

    always #5 bist_clk = ~bist_clk;

    int n_asserts = 0;
    int n_fail    = 0;

    // Engine behaviour per bank: done L cycles after enable (0 = never), fail pulses at offsets f1/f2 (0 = none)
    int L[4];
    int f1[4];
    int f2[4];
    int en_cyc[4];

    int         exp_en_bank[$];
    int         exp_en_cyc[$];
    int         got_en_bank[$];
    int         got_en_cyc[$];
    int         exp_done;
    logic [3:0] exp_fm;
    logic [3:0] exp_tm;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_asserts++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Reference: walk the banks, adding 2 cycles per skipped bank and wait+3 per tested bank
    task automatic model(input logic [3:0] m);
        int t;
        int w;
        bit to;
        exp_en_bank.delete();
        exp_en_cyc.delete();
        exp_fm = 4'b0;
        exp_tm = 4'b0;
        t      = 0;
        for (int b = 0; b < 4; b++) begin
            if (!m[b]) begin
                t += 2;
                continue;
            end
            exp_en_bank.push_back(b);
            exp_en_cyc.push_back(t + 1);
            to = (L[b] == 0) || (L[b] > T);
            w  = to ? T : L[b];
            if ((f1[b] >= 1 && f1[b] <= w) || (f2[b] >= 1 && f2[b] <= w)) exp_fm[b] = 1'b1;
            if (to) begin
                exp_fm[b] = 1'b1;
                exp_tm[b] = 1'b1;
            end
            t += w + 3;
`ifdef MBIST_SCHED_STOP_ON_FAIL_EN
            if (exp_fm[b]) break;
`endif
        end
        exp_done = (m == 4'b0) ? 0 : t;
    endtask

    task automatic sample_en(input int c);
        for (int b = 0; b < 4; b++) begin
            if (bist_test_enable[b]) begin
                got_en_bank.push_back(b);
                got_en_cyc.push_back(c);
                en_cyc[b] = c;
            end
        end
    endtask

    task automatic drive_engines(input int c, input logic [3:0] m);
        for (int b = 0; b < 4; b++) begin
            if (!m[b]) begin
                bist_done[b] = 1'($urandom);
                bist_fail[b] = 1'($urandom);
            end else begin
                bist_done[b] = (en_cyc[b] >= 0) && (L[b] != 0) && (c == en_cyc[b] + L[b]);
                bist_fail[b] = (en_cyc[b] >= 0) &&
                               ((f1[b] != 0 && c == en_cyc[b] + f1[b]) ||
                                (f2[b] != 0 && c == en_cyc[b] + f2[b]));
            end
        end
    endtask

    task automatic clear_run();
        got_en_bank.delete();
        got_en_cyc.delete();
        for (int b = 0; b < 4; b++) en_cyc[b] = -1;
    endtask

    task automatic set_engines(input int lat, input int fa, input int fb);
        for (int b = 0; b < 4; b++) begin
            L[b]  = lat;
            f1[b] = fa;
            f2[b] = fb;
        end
    endtask

    // One full sequence; optionally pulses a second start mid-run that must be ignored
    task automatic run(input logic [3:0] m, input bit inject);
        model(m);
        clear_run();
        @(negedge bist_clk);
        sched_start = 1'b1;
        bank_mask   = m;
        for (int c = 0; c <= exp_done + 2; c++) begin
            @(negedge bist_clk);
            sched_start = 1'b0;
            sample_en(c);
            check("busy", 32'(sched_busy), 32'(c <= exp_done));
            check("func_hold", 32'(func_hold), 32'(c <= exp_done));
            check("sched_done", 32'(sched_done), 32'(c == exp_done));
            if (c == exp_done) check("sched_pass", 32'(sched_pass), 32'(exp_fm == 4'b0));
            if (c == 0) check("maps_cleared", 32'({fail_map, timeout_map}), 32'(0));
            if (inject && exp_done >= 3 && c == 2) begin
                sched_start = 1'b1;
                bank_mask   = ~m;
            end
            drive_engines(c, m);
        end
        bist_done = 4'b0;
        bist_fail = 4'b0;
        check("enable_count", 32'(got_en_bank.size()), 32'(exp_en_bank.size()));
        for (int i = 0; i < exp_en_bank.size() && i < got_en_bank.size(); i++) begin
            check("enable_bank", 32'(got_en_bank[i]), 32'(exp_en_bank[i]));
            check("enable_cycle", 32'(got_en_cyc[i]), 32'(exp_en_cyc[i]));
        end
        check("fail_map", 32'(fail_map), 32'(exp_fm));
        check("timeout_map", 32'(timeout_map), 32'(exp_tm));
    endtask

    initial begin
        bist_reset_n = 1'b0;
        sched_start  = 1'b0;
        sched_abort  = 1'b0;
        bank_mask    = 4'b0;
        bist_done    = 4'b0;
        bist_fail    = 4'b0;
        clear_run();
        set_engines(10, 0, 0);
        repeat (3) @(negedge bist_clk);
        check("reset_outputs", 32'({bist_test_enable, func_hold, sched_busy, sched_done, sched_pass,
                                    cur_bank, fail_map, timeout_map}), 32'(0));
        bist_reset_n = 1'b1;
        repeat (2) @(negedge bist_clk);
        check("idle_after_reset", 32'({sched_busy, sched_done, bist_test_enable}), 32'(0));

        // All banks, clean engines
        set_engines(10, 0, 0);
        run(4'b1111, 1'b0);
        // Sparse mask, skipped banks take two cycles each
        set_engines(7, 0, 0);
        run(4'b1010, 1'b1);
        check("cur_bank_last", 32'(cur_bank), 32'(3));
        // Bank 2 fails twice before done
        set_engines(8, 0, 0);
        f1[2] = 3;
        f2[2] = 5;
        run(4'b1111, 1'b0);
        // Bank 1 never done -> timeout
        set_engines(6, 0, 0);
        L[1] = 0;
        run(4'b1111, 1'b0);
        // Done on exactly the last watchdog cycle, and one cycle too late
        L[1] = T;
        run(4'b0110, 1'b0);
        L[1] = T + 1;
        run(4'b0110, 1'b0);
        // Fail on the same cycle as done
        set_engines(5, 5, 0);
        run(4'b0001, 1'b0);
        // Empty mask
        run(4'b0000, 1'b0);

        // Abort while waiting on bank 1
        set_engines(10, 0, 0);
        L[0]  = 4;
        f1[0] = 2;
        L[1]  = 0;
        clear_run();
        @(negedge bist_clk);
        sched_start = 1'b1;
        bank_mask   = 4'b1111;
        for (int c = 0; c < 40; c++) begin
            @(negedge bist_clk);
            sched_start = 1'b0;
            sample_en(c);
            if (en_cyc[1] >= 0 && c == en_cyc[1] + 3) begin
                sched_abort = 1'b1;
                break;
            end
            drive_engines(c, 4'b1111);
        end
        check("abort_reached_bank1", 32'(sched_abort), 32'(1));
        bist_done = 4'b0;
        bist_fail = 4'b0;
        @(negedge bist_clk);
        sched_abort = 1'b0;
        check("abort_idle", 32'({sched_busy, func_hold, sched_done}), 32'(0));
        check("abort_cur_bank", 32'(cur_bank), 32'(1));
        check("abort_fail_map", 32'(fail_map), 32'(4'b0001));
        check("abort_timeout_map", 32'(timeout_map), 32'(0));
        bist_done[1] = 1'b1;
        bist_fail[1] = 1'b1;
        @(negedge bist_clk);
        bist_done = 4'b0;
        bist_fail = 4'b0;
        @(negedge bist_clk);
        check("late_done_ignored", 32'({sched_busy, sched_done, fail_map}), 32'(4'b0001));
        set_engines(5, 0, 0);
        run(4'b0010, 1'b0);

        // Randomized sequences
        for (int r = 0; r < 25; r++) begin
            for (int b = 0; b < 4; b++) begin
                L[b]  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, T + 4));
                f1[b] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, T + 4)) : 0;
                f2[b] = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, T + 4)) : 0;
            end
            run(4'($urandom), 1'($urandom));
        end

        // Asynchronous reset in the middle of a wait
        set_engines(0, 0, 0);
        clear_run();
        @(negedge bist_clk);
        sched_start = 1'b1;
        bank_mask   = 4'b1111;
        @(negedge bist_clk);
        sched_start = 1'b0;
        repeat (5) @(negedge bist_clk);
        check("busy_before_reset", 32'(sched_busy), 32'(1));
        bist_reset_n = 1'b0;
        #1;
        check("async_reset_outputs", 32'({bist_test_enable, func_hold, sched_busy, sched_done, sched_pass,
                                          cur_bank, fail_map, timeout_map}), 32'(0));
        repeat (2) @(negedge bist_clk);
        bist_reset_n = 1'b1;
        set_engines(3, 0, 0);
        run(4'b1001, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
